// File: rtl/cache_ri_dre_ctrl_if.sv
// Command and dre refill/interface port bundle for cache_ri_dre_ctrl.
// master is the controller view; slave is the refill engine and dre view.
interface cache_ri_dre_ctrl_if #(
  parameter int ADDR_WIDTH      = 8,
  parameter int LINE_WORDS_LOG2 = 3
);
  logic                                  cmd_valid;
  logic                                  cmd_ready;
  logic [1:0]                            cmd_op;
  logic [ADDR_WIDTH-LINE_WORDS_LOG2-1:0] cmd_line;
  logic [1:0]                            cmd_channel;
  logic                                  done;
  logic                                  done_full;
  logic                                  done_any;
  logic                                  sel;
  logic [ADDR_WIDTH:0]                   ri_readAddress;
  logic [1:0]                            ri_readChannel;
  logic [7:0]                            ri_readData;
  logic [ADDR_WIDTH-1:0]                 ri_writeAddress;
  logic [1:0]                            ri_writeChannel;
  logic                                  ri_writeEnable;
  logic [7:0]                            ri_writeData;

  modport master (
    input  cmd_valid, cmd_op, cmd_line, cmd_channel,
    input  ri_readData,
    output cmd_ready, done, done_full, done_any, sel,
    output ri_readAddress, ri_readChannel,
    output ri_writeAddress, ri_writeChannel,
    output ri_writeEnable, ri_writeData
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_line, cmd_channel,
    output ri_readData,
    input  cmd_ready, done, done_full, done_any, sel,
    input  ri_readAddress, ri_readChannel,
    input  ri_writeAddress, ri_writeChannel,
    input  ri_writeEnable, ri_writeData
  );
endinterface

// File: rtl/cache_ri_dre_ctrl.sv
// Line-level fill/clear/query walker for the dre tracking RAM ri port.
// Visits one dre entry of the line per cycle while holding sel.
module cache_ri_dre_ctrl #(
  parameter int ADDR_WIDTH      = 8,
  parameter int LINE_WORDS_LOG2 = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  cache_ri_dre_ctrl_if.master ctrl_io
);
  localparam int LW   = ADDR_WIDTH - LINE_WORDS_LOG2;
  localparam int EW   = ADDR_WIDTH - 1;
  localparam int CW   = LINE_WORDS_LOG2 - 1;
  localparam int CNTW = (CW > 0) ? CW : 1;
  localparam int N    = 1 << CW;

  typedef enum logic [2:0] {
    IDLE, WRITE, READ, DRAIN, DONE
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [LW-1:0]   line_q, line_d;
  logic [1:0]      ch_q, ch_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            acc_and_q, acc_and_d;
  logic            acc_or_q, acc_or_d;

  logic [EW-1:0] ent;
  logic          cnt_last;
  logic          rd_full;
  logic          rd_any;

  // Line base plus counter; the counter never spills into the line bits.
  assign ent      = (EW'(line_q) << CW) | EW'(cnt_q);
  assign cnt_last = (cnt_q == CNTW'(N - 1));
  assign rd_full  = (ctrl_io.ri_readData == 8'hFF);
  assign rd_any   = (ctrl_io.ri_readData != 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= 2'd0;
      line_q    <= '0;
      ch_q      <= 2'd0;
      cnt_q     <= '0;
      acc_and_q <= 1'b0;
      acc_or_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      line_q    <= line_d;
      ch_q      <= ch_d;
      cnt_q     <= cnt_d;
      acc_and_q <= acc_and_d;
      acc_or_q  <= acc_or_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    line_d    = line_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    acc_and_d = acc_and_q;
    acc_or_d  = acc_or_q;

    ctrl_io.cmd_ready       = 1'b0;
    ctrl_io.done            = 1'b0;
    ctrl_io.done_full       = 1'b0;
    ctrl_io.done_any        = 1'b0;
    ctrl_io.sel             = 1'b0;
    ctrl_io.ri_readAddress  = '0;
    ctrl_io.ri_readChannel  = 2'd0;
    ctrl_io.ri_writeAddress = '0;
    ctrl_io.ri_writeChannel = 2'd0;
    ctrl_io.ri_writeEnable  = 1'b0;
    ctrl_io.ri_writeData    = 8'h00;

    unique case (state_q)
      IDLE: begin
        ctrl_io.cmd_ready = 1'b1;
        if (ctrl_io.cmd_valid) begin
          op_d   = ctrl_io.cmd_op;
          line_d = ctrl_io.cmd_line;
          ch_d   = ctrl_io.cmd_channel;
          cnt_d  = '0;
          unique case (1'b1)
            (ctrl_io.cmd_op == 2'd2): begin
              state_d   = READ;
              acc_and_d = 1'b1;
              acc_or_d  = 1'b0;
            end
            (ctrl_io.cmd_op == 2'd3): state_d = DONE;
            default:                  state_d = WRITE;
          endcase
        end
      end
      WRITE: begin
        ctrl_io.sel             = 1'b1;
        ctrl_io.ri_writeEnable  = 1'b1;
        ctrl_io.ri_writeAddress = {ent, 1'b0};
        ctrl_io.ri_writeChannel = ch_q;
        ctrl_io.ri_writeData    = (op_q == 2'd0) ? 8'hFF : 8'h00;
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      READ: begin
        ctrl_io.sel            = 1'b1;
        ctrl_io.ri_readAddress = {ent, 2'b00};
        ctrl_io.ri_readChannel = ch_q;
        // Data for the previous entry arrives one cycle after its address.
        if (cnt_q != '0) begin
          acc_and_d = acc_and_q & rd_full;
          acc_or_d  = acc_or_q | rd_any;
        end
        if (cnt_last) state_d = DRAIN;
        else          cnt_d   = cnt_q + CNTW'(1);
      end
      DRAIN: begin
        ctrl_io.sel            = 1'b1;
        ctrl_io.ri_readAddress = {ent, 2'b00};
        ctrl_io.ri_readChannel = ch_q;
        acc_and_d = acc_and_q & rd_full;
        acc_or_d  = acc_or_q | rd_any;
        cnt_d     = '0;
        state_d   = DONE;
      end
      DONE: begin
        ctrl_io.done = 1'b1;
        if (op_q == 2'd2) begin
          ctrl_io.done_full = acc_and_q;
          ctrl_io.done_any  = acc_or_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_ri_dre_ctrl.sv
// Bench for cache_ri_dre_ctrl with a behavioural dre RAM and line model.
module tb_cache_ri_dre_ctrl;
  localparam int AW = 8;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_ri_dre_ctrl_if #(.ADDR_WIDTH(AW), .LINE_WORDS_LOG2(3)) bus0 ();
  cache_ri_dre_ctrl_if #(.ADDR_WIDTH(AW), .LINE_WORDS_LOG2(1)) bus1 ();

  cache_ri_dre_ctrl #(.ADDR_WIDTH(AW), .LINE_WORDS_LOG2(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .ctrl_io(bus0.master)
  );
  cache_ri_dre_ctrl #(.ADDR_WIDTH(AW), .LINE_WORDS_LOG2(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ctrl_io(bus1.master)
  );

  logic [7:0] mem0 [4][128];
  logic [7:0] mem1 [4][128];
  logic [7:0] ref0 [4][128];

  int tests = 0;
  int fails = 0;

  always @(posedge clk) begin
    if (bus0.ri_writeEnable)
      mem0[bus0.ri_writeChannel][bus0.ri_writeAddress[AW-1:1]] <= bus0.ri_writeData;
    bus0.ri_readData <= mem0[bus0.ri_readChannel][bus0.ri_readAddress[AW:2]];
    if (bus1.ri_writeEnable)
      mem1[bus1.ri_writeChannel][bus1.ri_writeAddress[AW-1:1]] <= bus1.ri_writeData;
    bus1.ri_readData <= mem1[bus1.ri_readChannel][bus1.ri_readAddress[AW:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int ch, input int e, input logic [7:0] v);
    @(negedge clk);
    mem0[ch][e] = v;
    ref0[ch][e] = v;
  endtask

  // Issue one command on dut0 and check every cycle up to completion.
  task automatic do_cmd(input int op, input int line, input int ch);
    int  dcyc;
    int  e;
    logic ef, ea;
    ef = 1'b0;
    ea = 1'b0;
    if (op == 2) begin
      ef = 1'b1;
      for (int k = 0; k < N; k++) begin
        if (ref0[ch][line*N+k] != 8'hFF) ef = 1'b0;
        if (ref0[ch][line*N+k] != 8'h00) ea = 1'b1;
      end
    end
    dcyc = (op == 3) ? 1 : (op == 2) ? N + 2 : N + 1;
    @(negedge clk);
    bus0.cmd_op      = 2'(op);
    bus0.cmd_line    = 5'(line);
    bus0.cmd_channel = 2'(ch);
    bus0.cmd_valid   = 1'b1;
    chk("ready_idle", bus0.cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus0.cmd_valid = 1'b0;
    for (int c = 1; c <= dcyc; c++) begin
      if (c < dcyc) begin
        chk("done_busy", bus0.done, 0);
        chk("sel_busy", bus0.sel, 1);
        chk("ready_busy", bus0.cmd_ready, 0);
        if (op < 2) begin
          chk("we", bus0.ri_writeEnable, 1);
          chk("waddr", bus0.ri_writeAddress, 2 * (line*N + c - 1));
          chk("wch", bus0.ri_writeChannel, ch);
          chk("wdata", bus0.ri_writeData, (op == 0) ? 8'hFF : 8'h00);
        end else begin
          e = line*N + ((c < N) ? c : N) - 1;
          chk("we_rd", bus0.ri_writeEnable, 0);
          chk("raddr", bus0.ri_readAddress, 4 * e);
          chk("rch", bus0.ri_readChannel, ch);
        end
        @(negedge clk);
      end else begin
        chk("done", bus0.done, 1);
        chk("done_full", bus0.done_full, ef);
        chk("done_any", bus0.done_any, ea);
        chk("sel_done", bus0.sel, 0);
        chk("we_done", bus0.ri_writeEnable, 0);
      end
    end
    @(negedge clk);
    chk("ready_after", bus0.cmd_ready, 1);
    chk("done_after", bus0.done, 0);
    if (op < 2)
      for (int k = 0; k < N; k++)
        ref0[ch][line*N+k] = (op == 0) ? 8'hFF : 8'h00;
  endtask

  initial begin
    int pulses;
    int bad;
    rst_n = 1'b0;
    bus0.cmd_valid = 1'b0; bus0.cmd_op = '0; bus0.cmd_line = '0; bus0.cmd_channel = '0;
    bus1.cmd_valid = 1'b0; bus1.cmd_op = '0; bus1.cmd_line = '0; bus1.cmd_channel = '0;
    for (int c = 0; c < 4; c++)
      for (int e = 0; e < 128; e++) begin
        mem0[c][e] = 8'h00;
        mem1[c][e] = 8'h00;
        ref0[c][e] = 8'h00;
      end
    #12;
    chk("rst_ready", bus0.cmd_ready, 1);
    chk("rst_done", bus0.done, 0);
    chk("rst_sel", bus0.sel, 0);
    chk("rst_we", bus0.ri_writeEnable, 0);
    chk("rst_waddr", bus0.ri_writeAddress, 0);
    chk("rst_raddr", bus0.ri_readAddress, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_cmd(0, 5, 2);
    do_cmd(2, 5, 2);
    do_cmd(1, 5, 2);
    poke(2, 22, 8'h0F);
    do_cmd(2, 5, 2);
    do_cmd(2, 6, 2);
    do_cmd(3, 7, 1);
    do_cmd(0, 31, 0);
    do_cmd(2, 31, 0);
    chk("no_wrap", mem0[0][0], ref0[0][0]);

    // Reset during cycle 2 of a fill.
    poke(2, 22, 8'h5A);
    @(negedge clk);
    bus0.cmd_op = 2'd0; bus0.cmd_line = 5'd5; bus0.cmd_channel = 2'd2;
    bus0.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus0.cmd_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_sel", bus0.sel, 0);
    chk("arst_we", bus0.ri_writeEnable, 0);
    chk("arst_ready", bus0.cmd_ready, 1);
    chk("arst_waddr", bus0.ri_writeAddress, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus0.done) pulses++;
    end
    chk("arst_nodone", pulses, 0);
    chk("arst_ready2", bus0.cmd_ready, 1);
    chk("arst_e20", mem0[2][20], 8'hFF);
    chk("arst_e21", mem0[2][21], 8'h00);
    chk("arst_e22", mem0[2][22], 8'h5A);
    chk("arst_e23", mem0[2][23], 8'h00);
    ref0[2][20] = 8'hFF;

    // cmd_valid held high across a whole fill.
    @(negedge clk);
    bus0.cmd_op = 2'd0; bus0.cmd_line = 5'd3; bus0.cmd_channel = 2'd1;
    bus0.cmd_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= N + 3; c++) begin
      @(negedge clk);
      if (c <= N + 1) chk("hold_ready", bus0.cmd_ready, 0);
      if (c == N + 1) chk("hold_done", bus0.done, 1);
      if (c == N + 2) chk("hold_ready2", bus0.cmd_ready, 1);
      if (c == N + 3) begin
        chk("hold_sel", bus0.sel, 1);
        chk("hold_waddr", bus0.ri_writeAddress, 2 * (3*N));
      end
    end
    bus0.cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("hold_idle", bus0.cmd_ready, 1);
    for (int k = 0; k < N; k++) ref0[1][3*N+k] = 8'hFF;

    for (int i = 0; i < 24; i++) begin
      int op, ln, ch, sw;
      op = $urandom_range(0, 3);
      ln = $urandom_range(0, 31);
      ch = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        sw = $urandom_range(0, 2);
        poke(ch, ln*N + $urandom_range(0, N-1),
             (sw == 0) ? 8'h00 : (sw == 1) ? 8'hFF : 8'($urandom_range(1, 254)));
      end
      do_cmd(op, ln, ch);
    end

    bad = 0;
    for (int c = 0; c < 4; c++)
      for (int e = 0; e < 128; e++)
        if (mem0[c][e] !== ref0[c][e]) bad++;
    chk("ram_model", bad, 0);

    // Single-entry lines: query and highest-line fill on dut1.
    @(negedge clk);
    mem1[0][9] = 8'hFF;
    bus1.cmd_op = 2'd2; bus1.cmd_line = 7'd9; bus1.cmd_channel = 2'd0;
    bus1.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.cmd_valid = 1'b0;
    chk("n1_sel1", bus1.sel, 1);
    chk("n1_raddr", bus1.ri_readAddress, 4 * 9);
    @(negedge clk);
    chk("n1_drain", bus1.sel, 1);
    chk("n1_nodone", bus1.done, 0);
    @(negedge clk);
    chk("n1_done", bus1.done, 1);
    chk("n1_full", bus1.done_full, 1);
    chk("n1_any", bus1.done_any, 1);
    @(negedge clk);
    bus1.cmd_op = 2'd0; bus1.cmd_line = 7'd127; bus1.cmd_channel = 2'd3;
    bus1.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.cmd_valid = 1'b0;
    chk("n1_we", bus1.ri_writeEnable, 1);
    chk("n1_waddr", bus1.ri_writeAddress, 254);
    @(negedge clk);
    chk("n1_wdone", bus1.done, 1);
    chk("n1_wfull", bus1.done_full, 0);
    chk("n1_top", mem1[3][127], 8'hFF);
    chk("n1_nowrap", mem1[3][0], 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cache_ri_dre_ctrl.md
# cache_ri_dre_ctrl

Line-level controller for the byte-readable (dre) tracking RAM's refill/interface port. On a command from the refill engine it marks a whole cache line readable, clears it, or queries it: it walks every dre entry of the line one per cycle and takes the port by asserting `sel`. It sits between the cache refill/invalidate state machine and the `ri_*` side of the dre block, and is the producer of the `ri_*` port that the dre block consumes.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: same value as the attached dre block; entry index `E` is `ADDR_WIDTH-1` bits.
- `LINE_WORDS_LOG2`, 3: log2 of 32-bit words per line. `N = 2**(LINE_WORDS_LOG2-1)` entries per line, because each entry covers 2 words. Legal range is 1..`ADDR_WIDTH-1`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `cmd_valid`, in, 1: command request.
- `cmd_ready`, out, 1: high only in IDLE.
- `cmd_op`, in, 2: 0 = fill (set all), 1 = clear, 2 = query, 3 = reserved.
- `cmd_line`, in, `ADDR_WIDTH-LINE_WORDS_LOG2`: line index.
- `cmd_channel`, in, 2: way/channel.
- `done`, out, 1: one-cycle completion pulse.
- `done_full`, out, 1: query result; every byte of the line is readable. Valid while `done` is high.
- `done_any`, out, 1: query result; at least one byte of the line is readable. Valid while `done` is high.
- `sel`, out, 1: port-ownership select to the dre block.
- `ri_readAddress`, out, `ADDR_WIDTH+1`: `{E,2'b00}`.
- `ri_readChannel`, out, 2.
- `ri_readData`, in, 8: entry bits. Registered RAM read with 1-cycle latency.
- `ri_writeAddress`, out, `ADDR_WIDTH`: `{E,1'b0}`.
- `ri_writeChannel`, out, 2.
- `ri_writeEnable`, out, 1.
- `ri_writeData`, out, 8.

## Operation
Command handling:
- Accept a command when `cmd_valid && cmd_ready`. Latch op, line and channel.
- Base entry `B = {cmd_line, (LINE_WORDS_LOG2-1)'b0}`.
- Entry counter `cnt`, `LINE_WORDS_LOG2-1` bits, starts at 0. Current entry `E = B + cnt`. The addition never carries out of the line.

States:
- IDLE: `cmd_ready=1`.
  - Op 0 or 1 -> WRITE.
  - Op 2 -> READ. Initialise the accumulators: `acc_and=1`, `acc_or=0`.
  - Op 3 -> DONE with no RAM access.
- WRITE:
  - Drive `ri_writeEnable=1`, write address from `E`, write channel = latched channel.
  - `ri_writeData` = 8'hFF for fill, 8'h00 for clear.
  - `cnt++`. When `cnt==N-1`, go to DONE.
- READ:
  - Drive read address from `E`, read channel = latched channel.
  - From the second READ cycle on, fold in the previous cycle's data: `acc_and &= (ri_readData==8'hFF)`, `acc_or |= (ri_readData!=0)`.
  - When `cnt==N-1`, go to DRAIN.
- DRAIN: fold in the last entry's data, then go to DONE. Read address is held.
- DONE:
  - `done=1` for one cycle, then IDLE.
  - For a query, `done_full = acc_and` and `done_any = acc_or`.
  - For fill, clear or op 3, both `done_full` and `done_any` are 0.

Output rules:
- `sel=1` in WRITE, READ and DRAIN. `sel=0` in IDLE and DONE.
- `ri_writeEnable` is never high outside WRITE.
- Address and channel outputs are registered-state derived. They are don't-care while `sel=0`, but are driven to 0 in IDLE.
- `cmd_valid` outside IDLE is ignored. There is no queueing.

## Timing
- Reset (async assert, sync deassert is the source's job):
  - State = IDLE, `cnt=0`.
  - `cmd_ready=1`.
  - `done`, `done_full`, `done_any`, `sel`, `ri_writeEnable` = 0.
  - All address, channel and data outputs = 0.
- Latency, with acceptance at edge 0:
  - Fill/clear: WRITE cycles 1..N, `done` at cycle N+1, `cmd_ready` again at N+2.
  - Query: READ cycles 1..N, DRAIN at N+1, `done` at N+2, `cmd_ready` again at N+3.
  - Op 3: `done` at cycle 1.
- Throughput: back-to-back commands are spaced by at least one IDLE cycle.
- Reset mid-operation: abort immediately and apply reset values. Partially written entries stay as written. `done` is not asserted.
- Counter wrap: `cnt` rolls from N-1 to 0 when leaving WRITE or DRAIN.
- With `LINE_WORDS_LOG2=1` (N=1):
  - WRITE lasts 1 cycle.
  - READ lasts 1 cycle with no fold; DRAIN performs the only fold.

## Test plan
- Fill (default params): op 0, line 5, ch 2.
  - Expect writes to entries 20,21,22,23, so `ri_writeAddress` = 40,42,44,46, with data FF and channel 2 on cycles 1-4.
  - `sel=1` on cycles 1-4; `done` on cycle 5 with `done_full=0`.
- Query after fill: op 2, line 5, ch 2.
  - `ri_readAddress` = 80,84,88,92 on cycles 1-4.
  - Expect `done` on cycle 6 with `done_full=1`, `done_any=1`.
- Clear then partial: clear line 5, write entry 22 to 8'h0F through the rw side, then query.
  - Expect `done_full=0`, `done_any=1`.
  - Querying line 6 after reset gives 0/0.
- Reset mid-op: assert `rst_n=0` on cycle 2 of a fill.
  - Outputs go to reset values asynchronously.
  - After release, `cmd_ready=1`, entry 20 is FF, entries 22-23 are unchanged, and `done` never pulses.
- Op 3 and ignored request: op 3 gives `done` on cycle 1 with no writes and `sel=0`.
  - `cmd_valid` held high through a fill is accepted only after the `done` cycle.
- Edge parameters: `LINE_WORDS_LOG2=1`, query of an FF entry gives `done` at cycle 3 with `done_full=1`.
  - Highest line index: entries end at `2**(ADDR_WIDTH-1)-1` with no address wrap into line 0.
